// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH         = 64,
  parameter int DEPTH              = 64,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       read_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       error_clear
);

  localparam int ADDR_WIDTH  = $clog2(DEPTH);
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]  storage [DEPTH];
  logic [ADDR_WIDTH-1:0]  write_pointer;
  logic [ADDR_WIDTH-1:0]  read_pointer;
  logic [COUNT_WIDTH-1:0] count;
  logic                   read_accept;
  logic                   write_accept;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign read_accept  = read_enable && !empty;
  assign write_accept = write_enable && (!full || read_accept);

  assign fill_count   = count;
  assign empty        = (count == '0);
  assign full         = (count == COUNT_WIDTH'(DEPTH));
  assign almost_full  = (count >= COUNT_WIDTH'(ALMOST_FULL_LEVEL));
  assign almost_empty = (count <= COUNT_WIDTH'(ALMOST_EMPTY_LEVEL));

  // NOTE: the storage array has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && write_accept) begin
      storage[write_pointer] <= write_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      read_data     <= '0;
      read_valid    <= 1'b0;
    end else begin
      read_valid <= read_accept;
      if (write_accept) begin
        write_pointer <= write_pointer + ADDR_WIDTH'(1);
      end
      if (read_accept) begin
        read_data    <= storage[read_pointer];
        read_pointer <= read_pointer + ADDR_WIDTH'(1);
      end
      case ({write_accept, read_accept})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;
  logic overflow_event;
  logic underflow_event;

  // A read on an empty FIFO that carries a write is not an underflow: the write is served.
  assign overflow_event  = write_enable && full && !read_accept;
  assign underflow_event = read_enable && empty && !write_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow_q <= 1'b1;
      end else if (error_clear) begin
        overflow_q <= 1'b0;
      end
      if (underflow_event) begin
        underflow_q <= 1'b1;
      end else if (error_clear) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_error_clear;
  assign unused_error_clear = error_clear;
  assign overflow           = 1'b0;
  assign underflow          = 1'b0;
`endif

  count_in_range : assert property (@(posedge clock) disable iff (reset)
    count <= COUNT_WIDTH'(DEPTH));

  flags_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(empty && full));

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboarded testbench for sync_fifo at DEPTH=8, DATA_WIDTH=64, thresholds 6/2.
module tb_sync_fifo;

  localparam int DW  = 64;
  localparam int DEP = 8;
  localparam int AFL = 6;
  localparam int AEL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          write_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          read_enable = 1'b0;
  logic          error_clear = 1'b0;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          empty, full, almost_empty, almost_full;
  logic [3:0]    fill_count;
  logic          overflow, underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow),
    .error_clear(error_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; the model predicts acceptance from its own count.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    int  cnt;
    bit  rd_acc, wr_acc, ovf_evt, unf_evt;
    logic [DW-1:0] exp_data;
    logic [3:0] exp_flags;
    cnt     = m_q.size();
    rd_acc  = re && (cnt != 0);
    wr_acc  = we && ((cnt != DEP) || rd_acc);
    ovf_evt = we && (cnt == DEP) && !rd_acc;
    unf_evt = re && (cnt == 0) && !we;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clock);
    #1;
    if (rd_acc) exp_q.push_back(m_q.pop_front());
    if (wr_acc) m_q.push_back(wd);
    if (ERR_EN) begin
      if (ovf_evt) m_ovf = 1'b1; else if (error_clear) m_ovf = 1'b0;
      if (unf_evt) m_unf = 1'b1; else if (error_clear) m_unf = 1'b0;
    end
    cnt = m_q.size();

    tests_run++;
    if (read_valid !== rd_acc) begin
      tests_failed++;
      $display("FAIL read_valid: got %b expected %b", read_valid, rd_acc);
    end
    if (rd_acc) begin
      exp_data = exp_q.pop_front();
      m_last   = exp_data;
    end else begin
      exp_data = m_last;
    end
    tests_run++;
    if (read_data !== exp_data) begin
      tests_failed++;
      $display("FAIL read_data: got %h expected %h", read_data, exp_data);
    end
    tests_run++;
    if (fill_count !== 4'(cnt)) begin
      tests_failed++;
      $display("FAIL fill_count: got %0d expected %0d", fill_count, cnt);
    end
    exp_flags = {cnt == 0, cnt == DEP, cnt <= AEL, cnt >= AFL};
    tests_run++;
    if ({empty, full, almost_empty, almost_full} !== exp_flags) begin
      tests_failed++;
      $display("FAIL flags(e,f,ae,af): got %b expected %b",
               {empty, full, almost_empty, almost_full}, exp_flags);
    end
    tests_run++;
    if ({overflow, underflow} !== {m_ovf, m_unf}) begin
      tests_failed++;
      $display("FAIL err_flags(ovf,unf): got %b expected %b", {overflow, underflow}, {m_ovf, m_unf});
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic apply_reset(input logic we);
    reset        = 1'b1;
    write_enable = we;
    write_data   = 64'hDEAD_BEEF;
    read_enable  = 1'b1;
    error_clear  = 1'b1;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    error_clear  = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    tests_run++;
    if ({read_valid, read_data, fill_count} !== {1'b0, 64'h0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_regs: got valid=%b data=%h count=%0d expected 0/0/0",
               read_valid, read_data, fill_count);
    end
    tests_run++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 110000",
               {empty, almost_empty, full, almost_full, overflow, underflow});
    end
    idle();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 6) begin
        tests_run++;
        if (almost_full !== 1'b1 || full !== 1'b0) begin
          tests_failed++;
          $display("FAIL almost_full_at_6: got af=%b f=%b expected af=1 f=0", almost_full, full);
        end
      end
    end
    tests_run++;
    if (full !== 1'b1 || fill_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL full_after_8: got full=%b count=%0d expected 1/8", full, fill_count);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1);
      tests_run++;
      if (read_data !== DW'(i)) begin
        tests_failed++;
        $display("FAIL drain_order: got %h expected %h", read_data, DW'(i));
      end
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_after_drain: got %b expected 1", empty);
    end
    idle();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) step(1'b1, 64'h1000 + DW'(i), 1'b0);
    step(1'b1, 64'hAA, 1'b0);
    tests_run++;
    if (fill_count !== 4'd8 || overflow !== ERR_EN) begin
      tests_failed++;
      $display("FAIL overflow_drop: got count=%0d ovf=%b expected 8/%b", fill_count, overflow, ERR_EN);
    end
    for (int i = 1; i <= 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    tests_run++;
    if (underflow !== ERR_EN) begin
      tests_failed++;
      $display("FAIL underflow_set: got %b expected %b", underflow, ERR_EN);
    end
    error_clear = 1'b1;
    step(1'b0, '0, 1'b1);
    tests_run++;
    if ({overflow, underflow} !== {1'b0, ERR_EN}) begin
      tests_failed++;
      $display("FAIL clear_vs_set: got %b expected %b", {overflow, underflow}, {1'b0, ERR_EN});
    end
    idle();
    error_clear = 1'b0;
    tests_run++;
    if ({overflow, underflow} !== 2'b00) begin
      tests_failed++;
      $display("FAIL error_clear: got %b expected 00", {overflow, underflow});
    end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 8; i++) step(1'b1, 64'h2000 + DW'(i), 1'b0);
    step(1'b1, 64'hBB, 1'b1);
    tests_run++;
    if (read_data !== 64'h2001 || fill_count !== 4'd8 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_rw: got data=%h count=%0d full=%b expected 2001/8/1",
               read_data, fill_count, full);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    tests_run++;
    if (read_data !== 64'hBB) begin
      tests_failed++;
      $display("FAIL full_rw_last: got %h expected bb", read_data);
    end
    idle();
  endtask

  task automatic test_empty_rw();
    step(1'b1, 64'hCC, 1'b1);
    tests_run++;
    if (read_valid !== 1'b0 || fill_count !== 4'd1 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_rw: got valid=%b count=%0d unf=%b expected 0/1/0",
               read_valid, fill_count, underflow);
    end
    step(1'b0, '0, 1'b1);
    tests_run++;
    if (read_data !== 64'hCC) begin
      tests_failed++;
      $display("FAIL empty_rw_read: got %h expected cc", read_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, {$urandom, $urandom}, 1'b1);
      tests_run++;
      if (fill_count !== 4'd3) begin
        tests_failed++;
        $display("FAIL b2b_count: got %0d expected 3", fill_count);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 64'h3000 + DW'(i), 1'b0);
    apply_reset(1'b1);
    tests_run++;
    if ({fill_count, empty, almost_empty, full, almost_full, read_valid} !== {4'd0, 5'b11000}) begin
      tests_failed++;
      $display("FAIL reset_mid: got count=%0d flags=%b expected 0/11000",
               fill_count, {empty, almost_empty, full, almost_full, read_valid});
    end
    step(1'b1, 64'hDD, 1'b0);
    step(1'b0, '0, 1'b1);
    tests_run++;
    if (read_data !== 64'hDD) begin
      tests_failed++;
      $display("FAIL reset_mid_read: got %h expected dd", read_data);
    end
    idle();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
